drm_stream_link_fifo: RTL
=========================

# drm_stream_link_fifo

Bidirectional AXI4-Stream buffering stage placed between one user-IP port pair of the DRM controller (drm_to_uipN / uipN_to_drm) and the DRM activator inside a compute unit. Each direction has an independent C_DEPTH-entry FIFO with fully registered tvalid/tready. This lets the controller-to-activator link be routed across SLR boundaries without combinational paths. The block carries data transparently and never alters, drops or reorders words.

## Interface
- C_DATA_WIDTH, 32, stream data width for both directions.
- C_DEPTH, 4, entries per direction; power of two, ≥ 2.
- LW (localparam), $clog2(C_DEPTH+1), width of the level outputs.

- ap_clk  in  1  single clock for all logic.
- ap_rst  in  1  reset, asynchronous, active-high.
- s_dn_tvalid  in  1  controller→activator word valid (from drm_to_uipN_tvalid).
- s_dn_tready  out  1  downstream FIFO can accept.
- s_dn_tdata  in  C_DATA_WIDTH  controller→activator data.
- m_dn_tvalid  out  1  word available to the activator.
- m_dn_tready  in  1  activator accepts.
- m_dn_tdata  out  C_DATA_WIDTH  data to the activator.
- s_up_tvalid  in  1  activator→controller word valid.
- s_up_tready  out  1  upstream FIFO can accept.
- s_up_tdata  in  C_DATA_WIDTH  activator→controller data.
- m_up_tvalid  out  1  word available to the controller (to uipN_to_drm_tvalid).
- m_up_tready  in  1  controller accepts.
- m_up_tdata  out  C_DATA_WIDTH  data to the controller.
- dn_level  out  LW  downstream FIFO occupancy.
- up_level  out  LW  upstream FIFO occupancy.

## Operation
- The two directions are identical, independent instances of the same FIFO. Rules below are per direction.
- Storage: C_DEPTH × C_DATA_WIDTH array, write pointer wp and read pointer rp, each log2(C_DEPTH) bits. Pointers wrap naturally at C_DEPTH−1 → 0. Occupancy register lvl runs 0..C_DEPTH.
- Push when s_tvalid && s_tready. Writes mem[wp]; wp+1.
- Pop when m_tvalid && m_tready. rp+1.
- lvl next = lvl + push − pop. A simultaneous push and pop leaves lvl unchanged.
- s_tready is a register: next value = (lvl_next < C_DEPTH). It never depends combinationally on m_tready.
- m_tvalid is a register: next value = (lvl_next > 0). m_tdata is a register loaded with mem[rp_next], or with the incoming s_tdata when lvl is 0 and a push occurs (bypass write).
- Full (lvl = C_DEPTH): s_tready = 0, so no push. A pop in that cycle raises s_tready on the next cycle.
- Empty (lvl = 0): m_tvalid = 0. Push on an empty FIFO makes m_tvalid = 1 on the next cycle.
- AXI rule: once asserted, m_tvalid stays high and m_tdata stays stable until the pop.
- dn_level/up_level = lvl, registered.
- Reset (asynchronous, any time including mid-transfer): wp = rp = lvl = 0, m_tvalid = 0, s_tready = 0, m_tdata = 0, levels = 0. Buffered words are discarded. s_tready rises on the first ap_clk edge after ap_rst deasserts.

## Timing
- Latency input handshake → m_tvalid: 1 cycle.
- Sustained throughput: 1 word/cycle when C_DEPTH ≥ 2 and the consumer is always ready.
- All outputs are driven directly from flops; no input-to-output combinational path.
- Reset values: s_dn_tready = s_up_tready = 0; m_dn_tvalid = m_up_tvalid = 0; m_dn_tdata = m_up_tdata = 0; dn_level = up_level = 0.

## Configuration
- DRM_LINK_STATS_EN defined adds two outputs, dn_words and up_words (each 32 bits). Each counts pops on its master side, saturates at 32'hFFFF_FFFF and resets to 0 on ap_rst.
- DRM_LINK_STATS_EN undefined: the counters and their ports do not exist. Behaviour is otherwise identical.

## Test plan
- Reset release, both tvalid inputs low → s_dn_tready/s_up_tready = 0 during reset, 1 on the first edge after release; m_*_tvalid stay 0; levels = 0.
- Push 0xA5A5_0001 downstream with m_dn_tready = 1 → m_dn_tvalid = 1 with that data exactly one cycle later; dn_level returns to 0 after the pop.
- Hold m_dn_tready = 0 and push 4 words 0x10..0x13 (C_DEPTH = 4) → dn_level = 4 and s_dn_tready = 0 the cycle after the 4th push. Release m_dn_tready → 0x10..0x13 appear in order and s_dn_tready returns to 1 the cycle after the first pop.
- Continuous streaming of 1000 words in both directions at once, both consumers always ready → one word per cycle, no loss, order preserved, up and down traffic independent.
- Assert ap_rst mid-burst with 2 words buffered → m_dn_tvalid drops immediately (asynchronously), dn_level = 0, and no stale word appears after release.
- With DRM_LINK_STATS_EN defined, pop 7 words up and 3 words down → up_words = 7, dn_words = 3; with the counter preloaded to 32'hFFFF_FFFE, three more pops → 32'hFFFF_FFFF.

Source files
------------

// File: rtl/drm_stream_link_fifo.sv
// Bidirectional registered AXI4-Stream FIFO pair between DRM controller and activator.
// Optional DRM_LINK_STATS_EN adds saturating per-direction pop counters.
module drm_link_fifo #(
    parameter int W = 32,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [W-1:0]           s_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [W-1:0]           m_tdata,
    output logic [$clog2(D+1)-1:0] level
);
    localparam int AW = $clog2(D);
    localparam int LW = $clog2(D+1);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW-1:0] rp_nx;
    logic [LW-1:0] lvl;
    logic [LW-1:0] lvl_nx;
    logic          push;
    logic          pop;

    assign push  = s_tvalid && s_tready;
    assign pop   = m_tvalid && m_tready;
    assign level = lvl;

    always_comb begin
        rp_nx  = rp + AW'(pop);
        lvl_nx = lvl + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= s_tdata;
    end

    // Head register: when the next head is the slot being written this
    // cycle, take it straight from the input instead of the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            lvl      <= '0;
            s_tready <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            rp       <= rp_nx;
            lvl      <= lvl_nx;
            s_tready <= (lvl_nx < LW'(D));
            m_tvalid <= (lvl_nx != '0);
            if (lvl_nx != '0)
                m_tdata <= (push && rp_nx == wp) ? s_tdata : mem[rp_nx];
        end
    end
endmodule

module drm_stream_link_fifo #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_DEPTH      = 4,
    localparam int LW          = $clog2(C_DEPTH+1)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    s_dn_tvalid,
    output logic                    s_dn_tready,
    input  logic [C_DATA_WIDTH-1:0] s_dn_tdata,
    output logic                    m_dn_tvalid,
    input  logic                    m_dn_tready,
    output logic [C_DATA_WIDTH-1:0] m_dn_tdata,
    input  logic                    s_up_tvalid,
    output logic                    s_up_tready,
    input  logic [C_DATA_WIDTH-1:0] s_up_tdata,
    output logic                    m_up_tvalid,
    input  logic                    m_up_tready,
    output logic [C_DATA_WIDTH-1:0] m_up_tdata,
    output logic [LW-1:0]           dn_level,
    output logic [LW-1:0]           up_level
`ifdef DRM_LINK_STATS_EN
    ,
    output logic [31:0]             dn_words,
    output logic [31:0]             up_words
`endif
);
    drm_link_fifo #(.W(C_DATA_WIDTH), .D(C_DEPTH)) u_dn (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .s_tvalid (s_dn_tvalid),
        .s_tready (s_dn_tready),
        .s_tdata  (s_dn_tdata),
        .m_tvalid (m_dn_tvalid),
        .m_tready (m_dn_tready),
        .m_tdata  (m_dn_tdata),
        .level    (dn_level)
    );

    drm_link_fifo #(.W(C_DATA_WIDTH), .D(C_DEPTH)) u_up (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .s_tvalid (s_up_tvalid),
        .s_tready (s_up_tready),
        .s_tdata  (s_up_tdata),
        .m_tvalid (m_up_tvalid),
        .m_tready (m_up_tready),
        .m_tdata  (m_up_tdata),
        .level    (up_level)
    );

`ifdef DRM_LINK_STATS_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            dn_words <= '0;
            up_words <= '0;
        end else begin
            if (m_dn_tvalid && m_dn_tready && dn_words != '1)
                dn_words <= dn_words + 32'd1;
            if (m_up_tvalid && m_up_tready && up_words != '1)
                up_words <= up_words + 32'd1;
        end
    end
`endif
endmodule
